// File: rtl/frame_swap_pkg.sv
// frame_swap_pkg: shared state encoding and defaults for the frame swap scheduler
package frame_swap_pkg;
  typedef enum logic [2:0] {IDLE, START, RENDER, WAIT_VBLANK, SWAP} swap_state_t;
  localparam int CNT_W_DEFAULT = 16;
endpackage

// File: rtl/vs_edge_detect.sv
// vs_edge_detect: resynchronises active-low vsync and emits a registered one-cycle pulse on its fall
module vs_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic vga_vs,
  output logic vs_fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q, fall_q;
  // Everything resets to the inactive (high) level so reset release never fakes a fall
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], vga_vs};
      prev_q <= sync_q[SYNC_STAGES-1];
      fall_q <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  assign vs_fall = fall_q;
endmodule

// File: rtl/frame_swap_scheduler.sv
// frame_swap_scheduler: starts GPU frames and swaps the double buffer only at vsync start
module frame_swap_scheduler
  import frame_swap_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             vga_vs,
  input  logic             gpu_done,
  input  logic             enable,
  output logic             gpu_start,
  output logic             write_buffer,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] dropped_count
);
  swap_state_t state_q, state_d;
  logic vs_fall, drop, start_q, busy_q, wb_q;
  logic [CNT_W-1:0] fc_q, dc_q;
  vs_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_vs (
    .Clk    (Clk),
    .Reset  (Reset),
    .vga_vs (vga_vs),
    .vs_fall(vs_fall)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = enable ? START : IDLE;
      START:       state_d = RENDER;
      RENDER:      state_d = gpu_done ? (vs_fall ? SWAP : WAIT_VBLANK) : RENDER;
      WAIT_VBLANK: state_d = vs_fall ? SWAP : WAIT_VBLANK;
      SWAP:        state_d = enable ? START : IDLE;
      default:     state_d = IDLE;
    endcase
  end
  // A vsync that arrives while the frame is still being drawn is a missed frame
  assign drop = (state_q == RENDER) && vs_fall && !gpu_done;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      wb_q    <= 1'b0;
      fc_q    <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= state_d == START;
      busy_q  <= state_d != IDLE;
      if (state_q == SWAP) begin
        wb_q <= ~wb_q;
        fc_q <= fc_q + CNT_W'(1);
      end
      if (drop && !(&dc_q)) dc_q <= dc_q + CNT_W'(1);
    end
  assign gpu_start     = start_q;
  assign busy          = busy_q;
  assign write_buffer  = wb_q;
  assign frame_count   = fc_q;
  assign dropped_count = dc_q;
endmodule

// File: tb/tb_frame_swap_scheduler.sv
// tb_frame_swap_scheduler: random stimulus against a transaction-level model with a decoupled scoreboard
module tb_frame_swap_scheduler;
  localparam int S  = 2;
  localparam int CW = 4;
  localparam int SAT = 2**CW - 1;
  logic Clk = 0, Reset = 1, vga_vs = 1, gpu_done = 0, enable = 1;
  logic gpu_start, write_buffer, busy;
  logic [CW-1:0] frame_count, dropped_count;
  int vectors = 0, errors = 0;
  logic [2*CW+2:0] snap_q[$], start_q[$];
  frame_swap_scheduler #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .vga_vs       (vga_vs),
    .gpu_done     (gpu_done),
    .enable       (enable),
    .gpu_start    (gpu_start),
    .write_buffer (write_buffer),
    .busy         (busy),
    .frame_count  (frame_count),
    .dropped_count(dropped_count)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, need %h", name, $time, got, exp);
    end
  endtask
  // Reference model: a frame is either parked, just started, in flight (maybe finished), or due to swap
  bit parked, fresh, finished, swap_now, last_vs;
  bit pend[8];
  logic m_wb;
  logic [CW-1:0] m_fc;
  int m_dc, k;
  task automatic model_reset();
    parked = 1; fresh = 0; finished = 0; swap_now = 0; last_vs = 1;
    m_wb = 0; m_fc = 0; m_dc = 0; k = 0;
    foreach (pend[i]) pend[i] = 0;
  endtask
  task automatic model_step(input logic vs, input logic done, input logic en);
    bit vsf, st;
    logic [CW-1:0] dcv;
    vsf = pend[k%8];
    st = 0;
    pend[k%8] = 0;
    if (!vs && last_vs) pend[(k+S+1)%8] = 1;
    last_vs = vs;
    k++;
    if (swap_now) begin
      swap_now = 0; m_wb = ~m_wb; m_fc++;
      if (en) begin fresh = 1; st = 1; end else parked = 1;
    end else if (parked) begin
      if (en) begin parked = 0; fresh = 1; st = 1; end
    end else if (fresh) fresh = 0;
    else if (vsf && (finished || done)) begin swap_now = 1; finished = 0; end
    else if (done) finished = 1;
    else if (vsf && m_dc < SAT) m_dc++;
    dcv = m_dc[CW-1:0];
    snap_q.push_back({st, !parked, m_wb, m_fc, dcv});
    if (st) start_q.push_back({st, !parked, m_wb, m_fc, dcv});
  endtask
  always @(posedge Clk) begin
    logic [2*CW+2:0] got, e;
    #1;
    got = {gpu_start, busy, write_buffer, frame_count, dropped_count};
    if (snap_q.size() > 0) begin
      e = snap_q.pop_front();
      check("cycle_outputs", 32'(got), 32'(e));
    end
    if (gpu_start) begin
      if (start_q.size() == 0) check("unexpected_gpu_start", 32'(got), 32'(0));
      else begin
        e = start_q.pop_front();
        check("start_frame_state", 32'(got), 32'(e));
      end
    end
  end
  int done_pct[6] = '{0, 10, 3, 25, 50, 5};
  int en_pct[6]   = '{100, 90, 100, 50, 80, 20};
  initial begin
    int vs_timer, rst_at;
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_values", 32'({gpu_start, busy, write_buffer, frame_count, dropped_count}), 32'(0));
    Reset = 0;
    vs_timer = 8;
    for (int p = 0; p < 6; p++) begin
      rst_at = (p == 0) ? -1 : int'($urandom_range(50, 450));
      for (int c = 0; c < 500; c++) begin
        if (vs_timer == 0) begin
          vga_vs = ~vga_vs;
          vs_timer = vga_vs ? $urandom_range(3, 25) : $urandom_range(1, 3);
        end else vs_timer--;
        gpu_done = $urandom_range(0, 99) < done_pct[p];
        if (p > 0 && $urandom_range(0, 29) == 0) enable = $urandom_range(0, 99) < en_pct[p];
        @(posedge Clk);
        model_step(vga_vs, gpu_done, enable);
        @(negedge Clk);
        if (c == rst_at) begin
          #2 Reset = 1;
          #1 check("async_reset", 32'({gpu_start, busy, write_buffer, frame_count, dropped_count}), 32'(0));
          model_reset();
          @(negedge Clk);
          Reset = 0;
        end
      end
      if (p == 0) check("dropped_saturates", 32'(dropped_count), 32'(SAT));
    end
    gpu_done = 0;
    enable = 0;
    @(posedge Clk);
    model_step(vga_vs, gpu_done, enable);
    @(negedge Clk);
    check("start_queue_drained", 32'(start_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/frame_swap_scheduler.md
# frame_swap_scheduler

Sequences the double-buffered frame store: it tells the GPU when to begin rendering a frame, tracks completion, and swaps the write/display buffer pair only at the start of VGA vertical sync, so the display never shows a partly drawn frame. It sits between the GPU core and the frame-buffer director. It runs in the GPU clock domain, resynchronises the VGA vertical-sync input, and drives the buffer-select and start signals the director consumes.

## Interface

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the vsync synchroniser; legal range 2–4.
- CNT_W, 16: width of the frame and dropped-frame counters.

Ports:
- Clk  in  1  GPU clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high; one clock, no other clock domains internally.
- vga_vs  in  1  VGA vertical sync, active-low, asynchronous to Clk.
- gpu_done  in  1  single-cycle pulse; GPU has finished writing the current frame.
- enable  in  1  level; allows new frames to be started.
- gpu_start  out  1  registered single-cycle pulse; GPU may begin the next frame.
- write_buffer  out  1  registered; index of the buffer the GPU writes. The director displays the other buffer.
- busy  out  1  registered; high in every state except IDLE.
- frame_count  out  CNT_W  registered; number of completed swaps, wraps modulo 2^CNT_W.
- dropped_count  out  CNT_W  registered; number of vsync starts that found the GPU still rendering, saturates at all-ones.

## Operation

- States: IDLE, START, RENDER, WAIT_VBLANK, SWAP.
- IDLE:
  - Moves to START when enable = 1.
  - Otherwise stays in IDLE.
- START:
  - gpu_start = 1 for exactly this cycle.
  - Always moves to RENDER.
- RENDER:
  - gpu_done alone: move to WAIT_VBLANK.
  - vs_fall alone: dropped_count increments (saturating) and the state stays RENDER.
  - gpu_done and vs_fall in the same cycle: move directly to SWAP; no drop is counted.
- WAIT_VBLANK:
  - vs_fall: move to SWAP.
  - gpu_done is ignored.
- SWAP:
  - Lasts one cycle.
  - On exit, write_buffer toggles and frame_count increments.
  - Next state is START if enable = 1, else IDLE.
- gpu_done is ignored in IDLE, START, WAIT_VBLANK and SWAP.
- vs_fall is a one-cycle pulse marking a high-to-low transition on the synchronised vga_vs.
- Deasserting enable never aborts a frame. The current frame is still swapped, and then the block parks in IDLE.
- The buffer the GPU is writing never changes mid-frame: write_buffer changes only on the SWAP exit.

## Timing

- Reset values:
  - state IDLE.
  - gpu_start 0, busy 0, write_buffer 0.
  - frame_count 0, dropped_count 0.
  - All synchroniser flops 1, which matches vsync inactive, so releasing reset cannot produce a spurious vs_fall.
- Reset asserted mid-operation returns everything to the values above immediately, asynchronously. Any swap in progress is lost.
- Latency from vga_vs falling (setup met before edge 1) to vs_fall high: SYNC_STAGES+1 edges.
- SWAP follows vs_fall by 1 edge. write_buffer toggles and gpu_start rises 1 edge after that, in the same cycle.
- Total latency from vsync fall to gpu_start: SYNC_STAGES+3 edges (5 with the default).
- enable = 1 in IDLE: gpu_start is high after 1 edge.
- The minimum gap between two gpu_start pulses is bounded by one vsync period. Only one swap happens per vsync.
- frame_count wraps from all-ones to 0. dropped_count holds at all-ones.

## Structure

- Package frame_swap_pkg holds:
  - typedef enum logic [2:0] swap_state_t {IDLE, START, RENDER, WAIT_VBLANK, SWAP};
  - the counter-width default constant.
- Sub-module vs_edge_detect (parameter SYNC_STAGES):
  - synchroniser chain with async reset to 1;
  - previous-value register;
  - vs_fall output.
- The top level holds the FSM, write_buffer, and both counters.

## Test plan

- Reset, enable=1, no further stimulus → gpu_start pulses 1 edge after the reset release edge with enable sampled high; busy=1; write_buffer=0.
- gpu_done in RENDER, then vga_vs falls → gpu_start again after 5 edges; write_buffer=1; frame_count=1; dropped_count=0.
- Three vsync falls while in RENDER with no gpu_done → dropped_count=3; write_buffer unchanged; no gpu_start.
- gpu_done in RENDER coincident with vs_fall → SWAP on the next edge; frame_count+1; dropped_count unchanged.
- enable dropped during RENDER, then gpu_done and vsync → one swap occurs, then IDLE, busy=0, no further gpu_start. Separately, gpu_done pulses in WAIT_VBLANK and IDLE are ignored.
- Reset asserted in WAIT_VBLANK with write_buffer=1, frame_count=5 → all outputs zero immediately; preset dropped_count=0xFFFF plus one more drop stays 0xFFFF (CNT_W=16).
